// File: rtl/reg_list_sequencer.sv
// Multi-register transfer engine for LDM/STM/PUSH/POP: walks a register mask,
// issues one word transfer per selected register and reports the writeback base.
module reg_list_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              dec_before,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [3:0]        rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [3:0]        rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              empty_err,
    output logic [ADDR_W-1:0] final_addr
);

    typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

    state_t            state;
    logic [15:0]       mask;
    logic [ADDR_W-1:0] cur_addr;
    logic              load_q;

    logic [4:0]        list_cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [3:0]        cur_idx;
    logic [15:0]       mask_nxt;
    logic              xfer;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    // Scanning downward leaves the lowest set bit, so low registers map to low addresses.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    assign list_cnt   = popcount16(reg_list);
    assign span       = {{(ADDR_W-7){1'b0}}, list_cnt, 2'b00};
    assign first_addr = dec_before ? base_addr - span : base_addr;
    assign end_addr   = dec_before ? base_addr - span : base_addr + span;
    assign cur_idx    = lowest_set(mask);
    assign mask_nxt   = mask & ~(16'h0001 << cur_idx);
    assign xfer       = (state == XFER);

    // Request side is decoded from registered state so it stays stable through stalls.
    assign mem_req      = xfer;
    assign mem_we       = xfer & ~load_q;
    assign mem_addr     = xfer ? cur_addr : '0;
    assign rf_read_addr = cur_idx;
    assign mem_wdata    = mem_we ? rf_read_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= '0;
            cur_addr      <= '0;
            load_q        <= 1'b0;
            final_addr    <= '0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            empty_err     <= 1'b0;
        end else begin
            rf_write_en <= 1'b0;
            done        <= 1'b0;
            empty_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        load_q     <= is_load;
                        mask       <= reg_list;
                        cur_addr   <= first_addr;
                        final_addr <= end_addr;
                        busy       <= 1'b1;
                        if (list_cnt == 5'd0) begin
                            state     <= FINISH;
                            done      <= 1'b1;
                            empty_err <= 1'b1;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        mask     <= mask_nxt;
                        cur_addr <= cur_addr + ADDR_W'(4);
                        if (load_q) begin
                            rf_write_en   <= 1'b1;
                            rf_write_addr <= cur_idx;
                            rf_write_data <= mem_rdata;
                        end
                        if (mask_nxt == 16'h0000) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_list_sequencer.md
Name: reg_list_sequencer

Overview:
- Multi-register transfer engine for LDM/STM/PUSH/POP in the mock ARMv7-M core.
- Acts as the initiator toward the 16-entry register file: it drives the read port for stores and the write port for loads.
- Walks a 16-bit register list and issues one word-wide memory transfer per selected register over a valid/ready memory port.
- Reports the updated base address for writeback.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data word width; must equal the register file width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- is_load  in  1  1 = LDM/POP (memory to registers), 0 = STM/PUSH (registers to memory); latched at start.
- dec_before  in  1  1 = decrement-before addressing (PUSH/STMDB), 0 = increment-after; latched at start.
- reg_list  in  16  register mask, bit i = Ri; latched at start.
- base_addr  in  ADDR_W  base register value; latched at start.
- rf_read_addr  out  4  register file read address (port 1).
- rf_read_data  in  DATA_W  combinational read data for rf_read_addr.
- rf_write_addr  out  4  register file write address.
- rf_write_data  out  DATA_W  register file write data.
- rf_write_en  out  1  register file write strobe.
- mem_req  out  1  transfer request (valid).
- mem_we  out  1  1 = write transfer.
- mem_addr  out  ADDR_W  word address of the transfer.
- mem_wdata  out  DATA_W  store data.
- mem_ready  in  1  transfer accepted this cycle.
- mem_rdata  in  DATA_W  load data, valid in the accept cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle completion pulse.
- empty_err  out  1  pulses with done when the latched reg_list is 0.
- final_addr  out  ADDR_W  writeback base; valid while done = 1 and held until the next start.

Behaviour:
- Reset: all outputs are 0, state = IDLE, internal mask = 0. Reset mid-operation abandons the transfer: mem_req and rf_write_en are low from the next cycle, and no partial done is produced.
- States: IDLE, XFER, FINISH.
- IDLE + start = 1:
  - Latch the inputs and compute n = popcount(reg_list).
  - First address: base_addr - 4n if dec_before, else base_addr.
  - final_addr = base_addr - 4n if dec_before, else base_addr + 4n. Arithmetic is modulo 2^ADDR_W.
  - Go to XFER, or to FINISH if n = 0.
- start while not IDLE is ignored.
- XFER:
  - The current register is the lowest set bit of the remaining mask, so the lowest register always goes to the lowest address.
  - mem_req = 1; mem_addr = current address; mem_we = !is_load.
  - Store: rf_read_addr = current index and mem_wdata = rf_read_data (combinational).
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ready = 1.
- Handshake (mem_req & mem_ready):
  - Clear the current mask bit and add 4 to the current address.
  - Load: register mem_rdata and the index; drive rf_write_en = 1 with them in the following cycle, exactly one cycle.
  - If the mask becomes empty, go to FINISH; otherwise stay in XFER with mem_req still high (back-to-back, no bubble).
- FINISH:
  - done = 1 for one cycle; empty_err = (n == 0); then go to IDLE.
  - For loads, the last rf_write_en coincides with the done cycle.
- Latency: with mem_ready tied high, a start sampled at edge 0 gives mem_req in cycles 1..n and done in cycle n+1. An empty list gives done in cycle 1.
- R15 in the list is treated like any other register; branch handling is outside this block.
- busy = (state != IDLE).

Test Plan:
- STM IA: base = 0x1000, list = 0x0016, mem_ready = 1, R1/R2/R4 = 0xA1/0xA2/0xA4 -> writes 0xA1@0x1000, 0xA2@0x1004, 0xA4@0x1008; done in cycle 4; final_addr = 0x100C.
- PUSH (dec_before): base = 0x2000, list = 0x4003 -> writes R0@0x1FF4, R1@0x1FF8, R14@0x1FFC; final_addr = 0x1FF4.
- LDM with stalls: list = 0x0081, mem_ready low 2 cycles per beat, mem_rdata = 0x55/0x77 -> address and request stable while stalled; rf writes R0 = 0x55, R7 = 0x77, each one cycle after its accept; done after the last accept.
- Empty list: list = 0, base = 0x3000 -> no mem_req; done and empty_err pulse in cycle 1; final_addr = 0x3000.
- Reset mid-operation: rst at the second beat of a 4-register STM -> mem_req = 0 next cycle, done never pulses, a new start is accepted afterwards.
- start asserted while busy, and address wrap with base = 0xFFFFFFFC, list = 0x0003 IA -> the second start is ignored; addresses are 0xFFFFFFFC then 0x00000000; final_addr = 0x00000004.
